// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: FSM states, opcodes, field positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  localparam int FIELD_W  = 8;
  localparam int OPC_LSB  = 24;
  localparam int DEST_LSB = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;

  // Opcodes are dense from 0x00; anything past beq halts the core.
  function automatic logic is_legal(input logic [7:0] op);
    return (op <= OP_BEQ);
  endfunction

endpackage

// File: rtl/reg_file_p.sv
// Register file: two combinational read ports, one clocked write port.
// Latency: reads 0 cycles, write visible after the next rising edge.
// Backpressure: none; a write is accepted every cycle WE is high.
module reg_file_p #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       WE,
  input  logic [$clog2(REG_N)-1:0]   WADDR,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [$clog2(REG_N)-1:0]   RADDR1,
  output logic [DATA_W-1:0]          RDATA1,
  input  logic [$clog2(REG_N)-1:0]   RADDR2,
  output logic [DATA_W-1:0]          RDATA2
);

  logic [DATA_W-1:0] regs [REG_N];

  // Reads see the pre-edge contents, so a same-cycle write never bypasses.
  assign RDATA1 = regs[RADDR1];
  assign RDATA2 = regs[RADDR2];

  // Synchronous clear of every entry, otherwise single-port write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (WE) begin
      regs[WADDR] <= WDATA;
    end
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Two-state multicycle core: FETCH latches an instruction, EXEC computes and retires it.
// Latency: 2 cycles per instruction plus one per stalled fetch cycle.
// Backpressure: FETCH holds PC and INSTR_READ while INSTR_BUSYWAIT is high.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8,
  parameter int PC_W   = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [31:0]     INSTRUCTION,
  input  logic            INSTR_BUSYWAIT,
  output logic [PC_W-1:0] PC,
  output logic            INSTR_READ,
  output logic            RETIRE,
  output logic            HALTED
);

  localparam int RI_W = $clog2(REG_N);

  state_t            state, state_nxt;
  logic [31:0]       ir;
  logic              ir_load;
  logic [PC_W-1:0]   pc_q, pc_nxt, pc_plus4, br_target, off_ext;

  logic [7:0]        opcode, dest_f, src1_f, src2_f;
  logic signed [7:0] imm_s, off_s;
  logic [DATA_W-1:0] imm_ext, rd1, rd2, alu_res;
  logic              wr_en, br_taken;
  logic              unused_src1_hi;

  assign opcode = ir[OPC_LSB  +: FIELD_W];
  assign dest_f = ir[DEST_LSB +: FIELD_W];
  assign src1_f = ir[SRC1_LSB +: FIELD_W];
  assign src2_f = ir[SRC2_LSB +: FIELD_W];

  // Only the low RI_W bits of SRC1 select a register.
  assign unused_src1_hi = ^src1_f;

  assign imm_s   = src2_f;
  assign off_s   = dest_f;
  assign imm_ext = DATA_W'(imm_s);
  assign off_ext = PC_W'(off_s);

  assign pc_plus4  = pc_q + PC_W'(4);
  assign br_target = pc_plus4 + (off_ext << 2);
  assign br_taken  = (opcode == OP_J) || ((opcode == OP_BEQ) && (rd1 == rd2));
  assign PC        = pc_q;

  reg_file_p #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_rf (
    .CLK    (CLK),
    .RESET  (RESET),
    .WE     (wr_en),
    .WADDR  (dest_f[RI_W-1:0]),
    .WDATA  (alu_res),
    .RADDR1 (src1_f[RI_W-1:0]),
    .RDATA1 (rd1),
    .RADDR2 (src2_f[RI_W-1:0]),
    .RDATA2 (rd2)
  );

  // Combinational ALU; add/sub wrap at DATA_W and drop the carry.
  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_LOADI: alu_res = imm_ext;
      OP_MOV:   alu_res = rd1;
      OP_ADD:   alu_res = rd1 + rd2;
      OP_SUB:   alu_res = rd1 + (~rd2 + DATA_W'(1));
      OP_AND:   alu_res = rd1 & rd2;
      OP_OR:    alu_res = rd1 | rd2;
      default:  alu_res = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, handshake outputs and write/PC control.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_q;
    wr_en      = 1'b0;
    ir_load    = 1'b0;
    INSTR_READ = 1'b0;
    RETIRE     = 1'b0;
    HALTED     = 1'b0;
    case (state)
      ST_FETCH: begin
        INSTR_READ = 1'b1;
        if (!INSTR_BUSYWAIT) begin
          ir_load   = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_legal(opcode)) begin
          RETIRE    = 1'b1;
          state_nxt = ST_FETCH;
          pc_nxt    = br_taken ? br_target : pc_plus4;
          wr_en     = (opcode != OP_J) && (opcode != OP_BEQ);
        end else begin
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        HALTED = 1'b1;
      end
      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

  // PC and instruction register; reset has priority over every update.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q <= '0;
      ir   <= '0;
    end else begin
      pc_q <= pc_nxt;
      if (ir_load) begin
        ir <= INSTRUCTION;
      end
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench: table-driven program run on 8-bit and 16-bit cores, plus stall/halt/reset sequences.
module tb_cpu_multicycle;
  import cpu_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        BUSYWAIT = 1'b0;
  logic [31:0] instr8, instr16;
  logic [31:0] pc8, pc16;
  logic        rd8, rd16, ret8, ret16, halt8, halt16;

  logic [31:0] imem [64];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign instr8  = imem[pc8[7:2]];
  assign instr16 = imem[pc16[7:2]];

  cpu_multicycle #(.DATA_W(8), .REG_N(8), .PC_W(32)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .INSTRUCTION    (instr8),
    .INSTR_BUSYWAIT (BUSYWAIT),
    .PC             (pc8),
    .INSTR_READ     (rd8),
    .RETIRE         (ret8),
    .HALTED         (halt8)
  );

  cpu_multicycle #(.DATA_W(16), .REG_N(8), .PC_W(32)) dut16 (
    .CLK            (CLK),
    .RESET          (RESET),
    .INSTRUCTION    (instr16),
    .INSTR_BUSYWAIT (BUSYWAIT),
    .PC             (pc16),
    .INSTR_READ     (rd16),
    .RETIRE         (ret16),
    .HALTED         (halt16)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] next_pc;
    int          rchk;
    logic [7:0]  e8;
    logic [15:0] e16;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for a retire on the 8-bit core; n = cycles waited.
  task automatic wait_retire(output int n);
    n = 0;
    while (ret8 !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic do_reset();
    RESET    = 1'b1;
    BUSYWAIT = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic fill_illegal();
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
  endtask

  task automatic load_table();
    fill_illegal();
    foreach (vecs[i]) imem[vecs[i].addr[7:2]] = vecs[i].instr;
  endtask

  function automatic logic [31:0] reg8(input int r);
    return {24'h0, dut.u_rf.regs[r]};
  endfunction

  function automatic logic [31:0] reg16(input int r);
    return {16'h0, dut16.u_rf.regs[r]};
  endfunction

  initial begin
    int n;

    //          addr    instr          next    reg  e8     e16
    vecs[0]  = '{32'h00, 32'h0004_0005, 32'h04, 4, 8'h05, 16'h0005};  // loadi r4,5
    vecs[1]  = '{32'h04, 32'h0002_0009, 32'h08, 2, 8'h09, 16'h0009};  // loadi r2,9
    vecs[2]  = '{32'h08, 32'h0206_0402, 32'h0C, 6, 8'h0E, 16'h000E};  // add r6,r4,r2
    vecs[3]  = '{32'h0C, 32'h0001_0003, 32'h10, 1, 8'h03, 16'h0003};  // loadi r1,3
    vecs[4]  = '{32'h10, 32'h0002_0005, 32'h14, 2, 8'h05, 16'h0005};  // loadi r2,5
    vecs[5]  = '{32'h14, 32'h0303_0102, 32'h18, 3, 8'hFE, 16'hFFFE};  // sub r3,r1,r2
    vecs[6]  = '{32'h18, 32'h0007_0080, 32'h1C, 7, 8'h80, 16'hFF80};  // loadi r7,0x80
    vecs[7]  = '{32'h1C, 32'h0405_0604, 32'h20, 5, 8'h04, 16'h0004};  // and r5,r6,r4
    vecs[8]  = '{32'h20, 32'h0500_0604, 32'h24, 0, 8'h0F, 16'h000F};  // or r0,r6,r4
    vecs[9]  = '{32'h24, 32'h0206_0606, 32'h28, 6, 8'h1C, 16'h001C};  // add r6,r6,r6
    vecs[10] = '{32'h28, 32'h0707_0201, 32'h2C, -1, 8'h00, 16'h0000}; // beq r2,r1 not taken
    vecs[11] = '{32'h2C, 32'h0701_0101, 32'h34, -1, 8'h00, 16'h0000}; // beq r1,r1 +1
    vecs[12] = '{32'h34, 32'h0601_0000, 32'h3C, -1, 8'h00, 16'h0000}; // j +1
    vecs[13] = '{32'h3C, 32'h0101_0300, 32'h40, 1, 8'hFE, 16'hFFFE};  // mov r1,r3
    vecs[14] = '{32'h40, 32'h07FE_0103, 32'h3C, -1, 8'h00, 16'h0000}; // beq r1,r3 -2

    // ---- reset state and table-driven program ----
    load_table();
    do_reset();
    chk("reset_pc", pc8, 32'h0);
    chk("reset_instr_read", {31'h0, rd8}, 32'h1);
    chk("reset_retire", {31'h0, ret8}, 32'h0);
    chk("reset_halted", {31'h0, halt8}, 32'h0);
    chk("reset_r4", reg8(4), 32'h0);

    foreach (vecs[i]) begin
      wait_retire(n);
      chk($sformatf("latency_%0d", i), n, 32'd1);
      chk($sformatf("exec_pc_%0d", i), pc8, vecs[i].addr);
      chk($sformatf("exec_read_%0d", i), {31'h0, rd8}, 32'h0);
      @(negedge CLK);
      chk($sformatf("next_pc_%0d", i), pc8, vecs[i].next_pc);
      chk($sformatf("next_pc16_%0d", i), pc16, vecs[i].next_pc);
      if (vecs[i].rchk >= 0) begin
        chk($sformatf("reg8_%0d", i), reg8(vecs[i].rchk), {24'h0, vecs[i].e8});
        chk($sformatf("reg16_%0d", i), reg16(vecs[i].rchk), {16'h0, vecs[i].e16});
      end
    end

    // ---- fetch stall on the second instruction ----
    do_reset();
    wait_retire(n);
    chk("stall_first_latency", n, 32'd1);
    @(negedge CLK);
    BUSYWAIT = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall_read_%0d", c), {31'h0, rd8}, 32'h1);
      chk($sformatf("stall_pc_%0d", c), pc8, 32'h4);
      chk($sformatf("stall_retire_%0d", c), {31'h0, ret8}, 32'h0);
      @(negedge CLK);
    end
    BUSYWAIT = 1'b0;
    wait_retire(n);
    chk("stall_second_latency", n, 32'd1);
    chk("stall_second_pc", pc8, 32'h4);

    // ---- reset during a stall after r5 has been written ----
    do_reset();
    for (int k = 0; k < 8; k++) begin
      wait_retire(n);
      @(negedge CLK);
    end
    chk("pre_rst_pc", pc8, 32'h20);
    chk("pre_rst_r5", reg8(5), 32'h04);
    BUSYWAIT = 1'b1;
    @(negedge CLK);
    chk("pre_rst_stalled_pc", pc8, 32'h20);
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_stall_rst_pc", pc8, 32'h0);
    chk("mid_stall_rst_r5", reg8(5), 32'h0);
    chk("mid_stall_rst_state", {30'h0, dut.state}, {30'h0, ST_FETCH});
    RESET    = 1'b0;
    BUSYWAIT = 1'b0;
    chk("mid_stall_rst_read", {31'h0, rd8}, 32'h1);

    // ---- jump then illegal opcode, halt, recovery ----
    RESET = 1'b1;
    fill_illegal();
    imem[0] = 32'h0601_0000;  // j +1 -> 0x08, which holds 0xFF
    do_reset();
    wait_retire(n);
    chk("j_latency", n, 32'd1);
    chk("j_exec_pc", pc8, 32'h0);
    @(negedge CLK);
    chk("j_target", pc8, 32'h8);
    @(negedge CLK);
    chk("ill_exec_retire", {31'h0, ret8}, 32'h0);
    chk("ill_exec_read", {31'h0, rd8}, 32'h0);
    @(negedge CLK);
    chk("halt_flag", {31'h0, halt8}, 32'h1);
    chk("halt_pc", pc8, 32'h8);
    chk("halt_read", {31'h0, rd8}, 32'h0);
    repeat (3) @(negedge CLK);
    chk("halt_hold_flag", {31'h0, halt8}, 32'h1);
    chk("halt_hold_pc", pc8, 32'h8);
    chk("halt_hold_retire", {31'h0, ret8}, 32'h0);
    RESET = 1'b1;
    @(negedge CLK);
    chk("unhalt_flag", {31'h0, halt8}, 32'h0);
    chk("unhalt_pc", pc8, 32'h0);
    RESET = 1'b0;
    chk("unhalt_read", {31'h0, rd8}, 32'h1);
    wait_retire(n);
    chk("unhalt_latency", n, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_multicycle.md
CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register/ALU data width (8..32).
REQ-002 SHALL have parameter REG_N, default 8, register count (power of two, 2..256); index width RI_W = clog2(REG_N).
REQ-003 SHALL have parameter PC_W, default 32, program counter width.
REQ-004 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port INSTRUCTION  input  32  fetched word, valid when INSTR_READ=1 and INSTR_BUSYWAIT=0.
REQ-007 SHALL have port INSTR_BUSYWAIT  input  1  instruction memory stall.
REQ-008 SHALL have port PC  output  PC_W  byte address of the instruction being fetched or executed.
REQ-009 SHALL have port INSTR_READ  output  1  fetch request.
REQ-010 SHALL have port RETIRE  output  1  one-cycle pulse per completed instruction.
REQ-011 SHALL have port HALTED  output  1  core stopped on an illegal opcode.

Function
REQ-012 SHALL decode OPCODE=[31:24], DEST=[23:16], SRC1=[15:8], SRC2/IMM=[7:0]; register indices use the low RI_W bits of each field.
REQ-013 SHALL implement opcodes 0x00 loadi, 0x01 mov, 0x02 add, 0x03 sub, 0x04 and, 0x05 or, 0x06 j, 0x07 beq; any other value is illegal.
REQ-014 SHALL sign-extend the 8-bit IMM to DATA_W for loadi.
REQ-015 SHALL compute add/sub modulo 2^DATA_W; sub = SRC1 + (~SRC2 + 1); carry is discarded.
REQ-016 SHALL use FSM states FETCH, EXEC, HALT; reset state FETCH.
REQ-017 FETCH: INSTR_READ=1; stays in FETCH while INSTR_BUSYWAIT=1; when INSTR_BUSYWAIT=0, latches INSTRUCTION into IR and moves to EXEC.
REQ-018 EXEC: INSTR_READ=0; one cycle; register write and PC update take effect on the EXEC->FETCH edge; RETIRE=1 during EXEC.
REQ-019 Non-branch: PC <= PC+4.
REQ-020 j: PC <= PC + 4 + (sext(DEST[7:0]) << 2), modulo 2^PC_W.
REQ-021 beq: taken when reg[SRC1] == reg[SRC2], target as for j; otherwise PC+4; no register write.
REQ-022 Register reads in EXEC return the value before the same-cycle write; DEST==SRC1 reads the old value.
REQ-023 Illegal opcode in EXEC: no register write, PC unchanged, RETIRE=0, go to HALT.
REQ-024 HALT: HALTED=1, INSTR_READ=0, no state changes until RESET.
REQ-025 Minimum latency 2 cycles per instruction, plus one cycle per INSTR_BUSYWAIT=1 cycle in FETCH.
REQ-026 PC wraps from 2^PC_W-4 to 0 without error.

Reset
REQ-027 On RESET=1 at a rising edge, SHALL set PC=0, state=FETCH, IR=0, all registers=0, RETIRE=0, HALTED=0, in any state including mid-stall and HALT.
REQ-028 During the RESET cycle itself, SHALL suppress register writes and PC updates; INSTR_READ=1 from the first cycle after RESET deasserts.

Structure
REQ-029 SHALL place opcode constants, FSM state encoding and field bit positions in shared package cpu_pkg.
REQ-030 SHALL implement the register file as sub-module reg_file_p (parameters DATA_W, REG_N; two async read ports, one sync write port, sync reset).
REQ-031 SHALL keep the ALU combinational inside cpu_multicycle; no added pipeline stages.

Verification
REQ-032 Reset then loadi r4,0x05; loadi r2,0x09; add r6,r4,r2 with BUSYWAIT=0 -> r6=0x0E, RETIRE on cycles 2,4,6, PC=0x0C after third retire.
REQ-033 loadi r1,0x03; loadi r2,0x05; sub r3,r1,r2 -> r3=0xFE (DATA_W=8); with DATA_W=16, r3=0xFFFE and loadi 0x80 -> 0xFF80.
REQ-034 BUSYWAIT=1 for 3 cycles on the second fetch -> INSTR_READ held, PC stable, second RETIRE delayed by 3 cycles.
REQ-035 beq r1,r1 with offset 0xFE at PC=0x10 -> next PC=0x0C; beq with unequal operands -> PC=0x14; j offset 0x01 at PC=0x00 -> PC=0x08.
REQ-036 Opcode 0xFF at PC=0x08 -> HALTED=1, PC stays 0x08, no RETIRE, INSTR_READ=0; RESET pulse -> HALTED=0, PC=0, fetch resumes.
REQ-037 RESET asserted during BUSYWAIT stall after r5 written -> next cycle PC=0, r5=0, state FETCH.
